fifo_sc_ctrl: RTL

FIFO_SC_CTRL -- requirements
Module: fifo_sc_ctrl

---
 rtl/fifo_sc_ctrl_pkg.sv | 15 +
 rtl/fifo_sc_ctrl_obuf.sv | 80 ++++++++
 rtl/fifo_sc_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/fifo_sc_ctrl_pkg.sv
// Shared definitions for the single-clock FIFO controller and its output buffer.
//   OBUF_DEPTH : number of entries in the output buffer (head + skid)
//   OBUF_CNT_W : width of the output-buffer occupancy count
//   occupancy(): converts the two entry flags into an occupancy count
package fifo_sc_ctrl_pkg;

   localparam int OBUF_DEPTH = 2;
   localparam int OBUF_CNT_W = 2;

   function automatic logic [OBUF_CNT_W-1:0] occupancy(input logic head_vld,
                                                       input logic skid_vld);
      return {1'b0, head_vld} + {1'b0, skid_vld};
   endfunction

endpackage

// File: rtl/fifo_sc_ctrl_obuf.sv
// fifo_obuf: 2-entry output buffer (head + skid) with valid/ready on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset (flags only)
//   in_data/in_valid    : word arriving from the RAM read port
//   in_ready            : high while the skid entry is free
//   out_data/out_valid  : head entry, presented downstream
//   out_ready           : downstream pop request
//   cnt                 : number of occupied entries (0..2)
module fifo_obuf
   import fifo_sc_ctrl_pkg::*;
#(
   parameter int DSIZE = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DSIZE-1:0]      in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DSIZE-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OBUF_CNT_W-1:0] cnt
);

   logic             head_vld;
   logic             skid_vld;
   logic [DSIZE-1:0] head;
   logic [DSIZE-1:0] skid;
   logic             push;
   logic             pop;

   assign in_ready  = ~skid_vld;
   assign push      = in_valid & in_ready;
   assign pop       = head_vld & out_ready;
   assign out_valid = head_vld;
   assign out_data  = head;
   assign cnt       = occupancy(head_vld, skid_vld);

   // Occupancy flags: the only state that reset touches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else if (pop) begin
         // Head leaves; skid (if any) moves up, and a simultaneous push
         // refills whichever slot becomes the tail.
         if (skid_vld) begin
            skid_vld <= push;
         end else begin
            head_vld <= push;
         end
      end else if (push) begin
         if (!head_vld) begin
            head_vld <= 1'b1;
         end else begin
            skid_vld <= 1'b1;
         end
      end
   end

   // Data entries: loaded under the same conditions, never reset.
   always_ff @(posedge clk) begin
      if (pop) begin
         if (skid_vld) begin
            head <= skid;
            if (push) begin
               skid <= in_data;
            end
         end else if (push) begin
            head <= in_data;
         end
      end else if (push) begin
         if (!head_vld) begin
            head <= in_data;
         end else begin
            skid <= in_data;
         end
      end
   end

endmodule

// File: rtl/fifo_sc_ctrl.sv
// fifo_sc_ctrl: single-clock FIFO controller driving an external dual-port RAM
// (port A write-only, port B read-only with one clock of read latency) and a
// 2-entry output buffer that hides the RAM read latency.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   s_data/s_valid/s_ready        : write side handshake
//   m_data/m_valid/m_ready        : read side handshake (head of FIFO)
//   ram_ena/ram_wea/ram_addra/ram_dia : RAM port A (write)
//   ram_enb/ram_addrb/ram_dob     : RAM port B (read, dob valid one clk after enb)
//   count                         : words held in RAM + in-flight read + buffer
module fifo_sc_ctrl
   import fifo_sc_ctrl_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DSIZE-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [DSIZE-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             ram_ena,
   output logic             ram_wea,
   output logic [ASIZE-1:0] ram_addra,
   output logic [DSIZE-1:0] ram_dia,
   output logic             ram_enb,
   output logic [ASIZE-1:0] ram_addrb,
   input  logic [DSIZE-1:0] ram_dob,
   output logic [ASIZE+1:0] count
);

   localparam int DEPTH = 2 ** ASIZE;
   localparam int RCW   = ASIZE + 1;
   localparam int CNT_W = ASIZE + 2;

   logic [ASIZE-1:0]      wptr;
   logic [ASIZE-1:0]      rptr;
   logic [RCW-1:0]        ram_cnt;
   logic                  rd_pend;
   logic                  write;
   logic                  rd_issue;
   logic                  pop;
   logic                  obuf_in_ready;
   logic [OBUF_CNT_W-1:0] obuf_cnt;
   logic [2:0]            fill_next;

   assign s_ready = (ram_cnt < RCW'(DEPTH));
   assign write   = s_valid & s_ready;
   assign pop     = m_valid & m_ready;

   // Buffer slots already spoken for after this edge; a new read is only
   // issued if its word is guaranteed a free slot when it lands next cycle.
   assign fill_next = 3'(obuf_cnt) + 3'(rd_pend) - 3'(pop);
   assign rd_issue  = (ram_cnt != '0) && (fill_next < 3'(OBUF_DEPTH));

   assign ram_ena   = write;
   assign ram_wea   = write;
   assign ram_addra = wptr;
   assign ram_dia   = s_data;
   assign ram_enb   = rd_issue;
   assign ram_addrb = rptr;

   assign count = CNT_W'(ram_cnt) + CNT_W'(obuf_cnt) + CNT_W'(rd_pend);

   // Stage 0 -> 1: pointers, RAM occupancy and read-in-flight flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr    <= '0;
         rptr    <= '0;
         ram_cnt <= '0;
         rd_pend <= 1'b0;
      end else begin
         if (write) begin
            wptr <= wptr + 1'b1;
         end
         if (rd_issue) begin
            rptr <= rptr + 1'b1;
         end
         ram_cnt <= ram_cnt + RCW'(write) - RCW'(rd_issue);
         rd_pend <= rd_issue;
      end
   end

   // Stage 1 -> 2: RAM read data lands in the output buffer.
   fifo_obuf #(
      .DSIZE (DSIZE)
   ) u_obuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (ram_dob),
      .in_valid  (rd_pend),
      .in_ready  (obuf_in_ready),
      .out_data  (m_data),
      .out_valid (m_valid),
      .out_ready (m_ready),
      .cnt       (obuf_cnt)
   );

   // The issue rule reserves a slot for every in-flight read, so the buffer
   // is always ready when rd_pend is high; in_ready is kept for the handshake.
   logic unused_in_ready;
   assign unused_in_ready = obuf_in_ready;

endmodule
